// File: rtl/cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cap_pkg
// Description : Shared definitions for the camera-buffer consumers: buffer
//               geometry, read-address field layout, RGB565 field slices and
//               the key-scanner state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cap_pkg;

  // Down-sampled frame buffer geometry
  localparam int BUF_COLS = 160;
  localparam int BUF_ROWS = 120;

  // Read-address layout: row in [24:18], column in [9:2], other bits zero
  localparam int ADDR_ROW_LSB = 18;
  localparam int ADDR_ROW_W   = $clog2(BUF_ROWS);
  localparam int ADDR_COL_LSB = 2;
  localparam int ADDR_COL_W   = $clog2(BUF_COLS);

  // RGB565 field positions
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // Key-scanner sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DECIDE = 2'd3
  } scan_state_e;

  // Pack a (row, column) pair into a buffer read address
  function automatic logic [31:0] make_addr(input logic [ADDR_ROW_W-1:0] row,
                                            input logic [ADDR_COL_W-1:0] col);
    logic [31:0] a;
    a = '0;
    a[ADDR_ROW_LSB +: ADDR_ROW_W] = row;
    a[ADDR_COL_LSB +: ADDR_COL_W] = col;
    return a;
  endfunction

endpackage : cap_pkg
`default_nettype wire

// File: rtl/rgb565_luma.sv
`default_nettype none
// ============================================================================
// Module      : rgb565_luma
// Description : Combinational RGB565 to 8-bit luma estimate,
//               Y = 2*R5 + G6 + B5 (range 0..156).
// Revision    : 1.0 - initial release
// ============================================================================
module rgb565_luma
  import cap_pkg::*;
(
  input  logic [15:0] pix,
  output logic [7:0]  luma
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  // Split the pixel and form the weighted sum; green already carries double weight
  always_comb begin
    r5   = pix[RGB_R_MSB:RGB_R_LSB];
    g6   = pix[RGB_G_MSB:RGB_G_LSB];
    b5   = pix[RGB_B_MSB:RGB_B_LSB];
    luma = {2'b00, r5, 1'b0} + {2'b00, g6} + {3'b000, b5};
  end

endmodule : rgb565_luma
`default_nettype wire

// File: rtl/key_scanner.sv
`default_nettype none
// ============================================================================
// Module      : key_scanner
// Description : Sweeps a band of the camera frame buffer, counts dark pixels
//               per key column-group and publishes a pressed-key bitmap once
//               per scan. Optional macro KEY_HYST_EN enables release
//               hysteresis (a pressed key holds while cnt >= COUNT_TH/2).
// Revision    : 1.0 - initial release
// ============================================================================
module key_scanner
  import cap_pkg::*;
#(
  parameter int NUM_KEYS  = 8,
  parameter int COL_START = 0,
  parameter int KEY_W     = 20,
  parameter int ROW_START = 80,
  parameter int ROW_END   = 95,
  parameter int LUMA_TH   = 40,
  parameter int COUNT_TH  = 100,
  parameter int CNT_W     = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [31:0]         rd_addr,
  input  logic [15:0]         pix_q,
  output logic                busy,
  output logic [NUM_KEYS-1:0] keys,
  output logic                keys_valid
);

  localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int KCW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  scan_state_e           state_q, state_d;
  logic [ADDR_ROW_W-1:0] row_q, row_d;
  logic [ADDR_COL_W-1:0] col_q, col_d;
  logic [KIW-1:0]        key_q, key_d;     // key of the address being presented
  logic [KCW-1:0]        kcol_q, kcol_d;   // column offset inside that key
  logic [KIW-1:0]        key_a_q, key_a_d; // key aligned with pix_q
  logic                  vld_q, vld_d;     // pix_q carries a scanned pixel
  logic [CNT_W-1:0]      cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]      cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]   keys_q, keys_d;
  logic [7:0]            luma;

  rgb565_luma u_luma (
    .pix  (pix_q),
    .luma (luma)
  );

  // Next-state: scan sequencing, dark-pixel counting and key decision
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    key_d   = key_q;
    kcol_d  = kcol_q;
    key_a_d = key_q;
    vld_d   = 1'b0;
    keys_d  = keys_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    // Pixel returned this cycle belongs to key_a_q; saturate rather than wrap
    if (vld_q && (luma < 8'(LUMA_TH)) && (cnt_q[key_a_q] != {CNT_W{1'b1}})) begin
      cnt_d[key_a_q] = cnt_q[key_a_q] + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          row_d   = ADDR_ROW_W'(ROW_START);
          col_d   = ADDR_COL_W'(COL_START);
          key_d   = '0;
          kcol_d  = '0;
          for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = '0;
          end
        end
      end
      ST_SCAN: begin
        vld_d = 1'b1;
        if (kcol_q == KCW'(KEY_W - 1)) begin
          kcol_d = '0;
          if (key_q == KIW'(NUM_KEYS - 1)) begin
            // End of the scanned column span: wrap to the next row
            key_d = '0;
            col_d = ADDR_COL_W'(COL_START);
            row_d = row_q + ADDR_ROW_W'(1);
            if (row_q == ADDR_ROW_W'(ROW_END)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            key_d = key_q + KIW'(1);
            col_d = col_q + ADDR_COL_W'(1);
          end
        end else begin
          kcol_d = kcol_q + KCW'(1);
          col_d  = col_q + ADDR_COL_W'(1);
        end
      end
      ST_DRAIN: begin
        // Final pixel is counted this cycle; decide from the updated counts so
        // the bitmap is already stable while keys_valid is high
        state_d = ST_DECIDE;
        for (int k = 0; k < NUM_KEYS; k++) begin
`ifdef KEY_HYST_EN
          if (keys_q[k]) begin
            keys_d[k] = (cnt_d[k] >= CNT_W'(COUNT_TH >> 1));
          end else begin
            keys_d[k] = (cnt_d[k] >= CNT_W'(COUNT_TH));
          end
`else
          keys_d[k] = (cnt_d[k] >= CNT_W'(COUNT_TH));
`endif
        end
      end
      ST_DECIDE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      key_q   <= '0;
      kcol_q  <= '0;
      key_a_q <= '0;
      vld_q   <= 1'b0;
      keys_q  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      key_q   <= key_d;
      kcol_q  <= kcol_d;
      key_a_q <= key_a_d;
      vld_q   <= vld_d;
      keys_q  <= keys_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign rd_addr    = (state_q == ST_SCAN) ? make_addr(row_q, col_q) : 32'd0;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign keys_valid = (state_q == ST_DECIDE);
  assign keys       = keys_q;

endmodule : key_scanner
`default_nettype wire
